// File: rtl/des_key_schedule_pkg.sv
// Shared constants for the iterative DES key schedule: PC-1/PC-2 tables,
// per-round shift amounts, FSM encoding and C/D rotation helpers.
package des_ks_pkg;

  localparam int KEY_W    = 64;
  localparam int CD_W     = 56;
  localparam int SUBKEY_W = 48;
  localparam int HALF_W   = 28;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Entries are DES bit numbers (1 = MSB) of the source vector.
  localparam int PC1 [CD_W] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [SUBKEY_W] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  localparam int SHIFT [1:16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  function automatic logic [16:1] shift_dbl_mask();
    logic [16:1] m;
    m = '0;
    for (int r = 1; r <= 16; r++) m[r[4:0]] = (SHIFT[r] == 2);
    return m;
  endfunction

  // Bit r set when round r shifts by two.
  localparam logic [16:1] SHIFT_DBL = shift_dbl_mask();

  function automatic logic [HALF_W-1:0] rot28(input logic [HALF_W-1:0] x,
                                              input logic left, input logic dbl);
    if (left)
      return dbl ? {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]} : {x[HALF_W-2:0], x[HALF_W-1]};
    else
      return dbl ? {x[1:0], x[HALF_W-1:2]} : {x[0], x[HALF_W-1:1]};
  endfunction

  function automatic logic [CD_W-1:0] rot_cd(input logic [CD_W-1:0] cd,
                                             input logic left, input logic dbl);
    return {rot28(cd[CD_W-1:HALF_W], left, dbl), rot28(cd[HALF_W-1:0], left, dbl)};
  endfunction

endpackage

// File: rtl/des_key_schedule_if.sv
// Key-load / subkey-issue handshake between the key schedule and its neighbours.
interface des_key_schedule_if;
  logic                              start;
  logic [des_ks_pkg::KEY_W-1:0]      key_in;
  logic                              decrypt;
  logic [des_ks_pkg::SUBKEY_W-1:0]   subkey_out;
  logic                              subkey_valid;
  logic                              subkey_ready;
  logic [3:0]                        round_idx;
  logic                              busy;
  logic                              done;
  logic                              parity_err;

  modport master (
    output start, key_in, decrypt, subkey_ready,
    input  subkey_out, subkey_valid, round_idx, busy, done, parity_err
  );

  modport slave (
    input  start, key_in, decrypt, subkey_ready,
    output subkey_out, subkey_valid, round_idx, busy, done, parity_err
  );
endinterface

// File: rtl/des_key_schedule_pc2.sv
// PC-2 compression permutation: 56-bit C/D register to 48-bit round subkey.
module des_pc2
  import des_ks_pkg::*;
(
  input  logic [CD_W-1:0]     i_cd,
  output logic [SUBKEY_W-1:0] o_subkey
);
  for (genvar i = 0; i < SUBKEY_W; i++) begin : g_bit
    assign o_subkey[SUBKEY_W-1-i] = i_cd[CD_W-PC2[i]];
  end

  // PC-2 drops eight C/D bits by design.
  logic w_unused;
  assign w_unused = ^i_cd;
endmodule

// File: rtl/des_key_schedule.sv
// Iterative DES subkey generator: one PC-2 subkey per handshake, K1..K16 or K16..K1.
// Optional DES_KS_PARITY_CHECK_EN rejects keys with any even-parity byte.
module des_key_schedule
  import des_ks_pkg::*;
#(
  parameter int NUM_ROUNDS = 16
)(
  input  logic               clk,
  input  logic               rst,
  des_key_schedule_if.slave  bus
);
  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS - 1);

  logic [1:0]          r_state;
  logic [CD_W-1:0]     r_cd;
  logic [3:0]          r_round;
  logic                r_dec;

  logic [CD_W-1:0]     w_pc1;
  logic [CD_W-1:0]     w_cd_nxt;
  logic [SUBKEY_W-1:0] w_pc2;
  logic [4:0]          w_sidx;
  logic                w_key_ok;
  logic                w_load;
  logic                w_hs;
  logic                w_valid;

  for (genvar i = 0; i < CD_W; i++) begin : g_pc1
    assign w_pc1[CD_W-1-i] = bus.key_in[KEY_W-PC1[i]];
  end

`ifdef DES_KS_PARITY_CHECK_EN
  logic [7:0] w_byte_odd;
  logic       r_perr;
  for (genvar b = 0; b < 8; b++) begin : g_par
    assign w_byte_odd[b] = ^bus.key_in[8*b +: 8];
  end
  assign w_key_ok = &w_byte_odd;

  always_ff @(posedge clk) begin
    if (rst) r_perr <= 1'b0;
    else     r_perr <= (r_state == S_IDLE) && bus.start && !w_key_ok;
  end
  assign bus.parity_err = r_perr;
`else
  assign w_key_ok       = 1'b1;
  assign bus.parity_err = 1'b0;
`endif

  assign w_load  = (r_state == S_IDLE) && bus.start && w_key_ok;
  assign w_valid = (r_state == S_RUN);
  assign w_hs    = w_valid && bus.subkey_ready;

  // Encrypt moves forward through SHIFT[idx+2]; decrypt undoes SHIFT[16-idx].
  // The encrypt index is clamped on the last round, where no rotation happens.
  assign w_sidx   = r_dec ? (5'd16 - {1'b0, r_round})
                          : ((r_round == LAST_RND) ? 5'd16 : ({1'b0, r_round} + 5'd2));
  assign w_cd_nxt = rot_cd(r_cd, !r_dec, SHIFT_DBL[w_sidx]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cd    <= '0;
      r_round <= '0;
      r_dec   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_load) begin
          r_state <= S_RUN;
          r_cd    <= bus.decrypt ? w_pc1 : rot_cd(w_pc1, 1'b1, SHIFT_DBL[1]);
          r_round <= '0;
          r_dec   <= bus.decrypt;
        end
        S_RUN: if (w_hs) begin
          if (r_round == LAST_RND) begin
            r_state <= S_DONE;
            r_round <= '0;
          end else begin
            r_round <= r_round + 4'd1;
            r_cd    <= w_cd_nxt;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  des_pc2 u_pc2 (
    .i_cd     (r_cd),
    .o_subkey (w_pc2)
  );

  assign bus.subkey_out   = w_valid ? w_pc2 : '0;
  assign bus.subkey_valid = w_valid;
  assign bus.busy         = w_valid;
  assign bus.done         = (r_state == S_DONE);
  assign bus.round_idx    = r_round;

  // Parity bits are not part of the key material.
  logic w_unused;
  assign w_unused = ^bus.key_in;
endmodule

// File: tb/tb_des_key_schedule.sv
// Scoreboard bench for des_key_schedule against a textbook DES key-schedule model.
module tb_des_key_schedule;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  des_key_schedule_if bus ();
  des_key_schedule dut (.clk(clk), .rst(rst), .bus(bus.slave));

  localparam logic [63:0] KEY0 = 64'h133457799BBCDFF1;
  localparam logic [47:0] K1   = 48'h1B02EFFC7072;
  localparam logic [47:0] K2   = 48'h79AED9DBC9E5;
  localparam logic [47:0] K16  = 48'hCB3D8B0E17F5;

  int TB_PC1 [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,
                      60,52,44,36,63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,
                      29,21,13,5,28,20,12,4};
  int TB_PC2 [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                      41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  int TB_SH  [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  int          n_chk  = 0;
  int          n_pass = 0;
  int          n_done = 0;
  int          n_sched = 0;
  bit          mon_en = 1'b0;
  bit          exp_done = 1'b0;
  logic [51:0] exp_q [$];
  logic [47:0] got_q [$];
  logic [47:0] mk [16];
  logic [47:0] enc_log [16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // All 16 subkeys in natural order from cumulative left shifts.
  task automatic build_model(input logic [63:0] key);
    logic [55:0] cd;
    logic [27:0] c, d;
    for (int i = 0; i < 56; i++) cd[55-i] = key[64-TB_PC1[i]];
    c = cd[55:28];
    d = cd[27:0];
    for (int r = 0; r < 16; r++) begin
      for (int s = 0; s < TB_SH[r]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int j = 0; j < 48; j++) mk[r][47-j] = cd[56-TB_PC2[j]];
    end
  endtask

  function automatic logic [63:0] odd_par(input logic [63:0] k);
    logic [63:0] r;
    r = k;
    for (int b = 0; b < 8; b++) r[8*b] = ~^r[8*b+1 +: 7];
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      exp_done = 1'b0;
    end else if (mon_en) begin
      chk("busy_eq_valid", bus.busy, bus.subkey_valid);
      if (exp_done) begin
        chk("done_after_last", bus.done, 1);
        chk("valid_after_last", bus.subkey_valid, 0);
        exp_done = 1'b0;
      end else if (bus.done) begin
        chk("done_spurious", bus.done, 0);
      end
      if (bus.done) n_done++;
      if (!bus.subkey_valid) begin
        chk("subkey_zero_idle", bus.subkey_out, 0);
        chk("round_zero_idle", bus.round_idx, 0);
      end else begin
        chk("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          chk("round_idx", bus.round_idx, exp_q[0][51:48]);
          chk("subkey", bus.subkey_out, exp_q[0][47:0]);
          if (bus.subkey_ready) begin
            got_q.push_back(bus.subkey_out);
            if (exp_q[0][51:48] == 4'd15) exp_done = 1'b1;
            void'(exp_q.pop_front());
          end
        end
      end
`ifndef DES_KS_PARITY_CHECK_EN
      chk("parity_zero", bus.parity_err, 0);
`endif
    end
  end

  // mode 0: ready=1, 1: stall 3 at idx 5, 2: start at idx 7, 3: rst at idx 9, 4: random ready
  task automatic run_sched(input logic [63:0] key, input bit dec, input int mode, output int cycles);
    int stall;
    bit fin;
    bit injected;
    stall = 0; fin = 1'b0; injected = 1'b0;
    build_model(key);
    got_q.delete();
    for (int p = 0; p < 16; p++) exp_q.push_back({4'(p), mk[dec ? 15-p : p]});
    bus.start = 1'b1; bus.key_in = key; bus.decrypt = dec;
    bus.subkey_ready = (mode == 4) ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.key_in = {$urandom, $urandom}; bus.decrypt = 1'($urandom_range(0, 1));
    chk("first_valid_latency", bus.subkey_valid, 1);
    cycles = 0;
    while (!fin && cycles < 400) begin
      bus.start = 1'b0;
      case (mode)
        1: if (bus.round_idx == 4'd5 && stall < 3) begin
             bus.subkey_ready = 1'b0; stall++;
           end else bus.subkey_ready = 1'b1;
        2: begin
             bus.subkey_ready = 1'b1;
             if (bus.round_idx == 4'd7 && !injected) begin
               bus.start = 1'b1; bus.key_in = 64'h0E329232EA6D0D73; bus.decrypt = 1'b1;
               injected = 1'b1;
             end
           end
        3: if (bus.round_idx == 4'd9) begin
             rst = 1'b1; bus.start = 1'b1; bus.key_in = KEY0;
             exp_q.delete();
             @(posedge clk); #1;
             rst = 1'b0; bus.start = 1'b0;
             chk("rst_valid", bus.subkey_valid, 0);
             chk("rst_busy", bus.busy, 0);
             chk("rst_round", bus.round_idx, 0);
             chk("rst_subkey", bus.subkey_out, 0);
             chk("rst_done", bus.done, 0);
             fin = 1'b1;
           end
        4: bus.subkey_ready = ($urandom_range(0, 2) != 0);
        default: bus.subkey_ready = 1'b1;
      endcase
      if (!fin) begin
        @(posedge clk); #1;
        cycles++;
        if (bus.done) fin = 1'b1;
      end
    end
    bus.start = 1'b0;
    if (mode != 3) begin
      chk("done_seen", fin, 1);
      chk("sb_drained", exp_q.size(), 0);
      n_sched++;
    end
    if (!fin) exp_q.delete();
    bus.subkey_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int cyc;
    bit same;
    logic [63:0] k;
    rst = 1'b1; bus.start = 1'b0; bus.key_in = '0; bus.decrypt = 1'b0; bus.subkey_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", bus.subkey_valid, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_round", bus.round_idx, 0);
    chk("reset_subkey", bus.subkey_out, 0);
    chk("reset_perr", bus.parity_err, 0);
    rst = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;

    run_sched(KEY0, 1'b0, 0, cyc);
    chk("burst_cycles", cyc, 16);
    chk("enc_len", got_q.size(), 16);
    chk("enc_K1", got_q[0], K1);
    chk("enc_K2", got_q[1], K2);
    chk("enc_K16", got_q[15], K16);
    for (int i = 0; i < 16; i++) enc_log[i] = got_q[i];

    run_sched(KEY0, 1'b1, 0, cyc);
    chk("dec_first", got_q[0], K16);
    chk("dec_last", got_q[15], K1);
    same = 1'b1;
    for (int i = 0; i < 16; i++) if (got_q[i] !== enc_log[15-i]) same = 1'b0;
    chk("dec_reverse", same, 1);

    run_sched(KEY0, 1'b0, 1, cyc);
    same = (got_q.size() == 16);
    for (int i = 0; i < 16 && same; i++) if (got_q[i] !== enc_log[i]) same = 1'b0;
    chk("stall_seq", same, 1);

    run_sched(KEY0, 1'b0, 2, cyc);
    same = (got_q.size() == 16);
    for (int i = 0; i < 16 && same; i++) if (got_q[i] !== enc_log[i]) same = 1'b0;
    chk("start_ignored_seq", same, 1);

    run_sched(KEY0, 1'b0, 3, cyc);
    run_sched(KEY0, 1'b0, 0, cyc);
    chk("post_rst_K1", got_q[0], K1);

`ifdef DES_KS_PARITY_CHECK_EN
    bus.start = 1'b1; bus.key_in = 64'h0; bus.decrypt = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("perr_set", bus.parity_err, 1);
    chk("perr_no_valid", bus.subkey_valid, 0);
    @(posedge clk); #1;
    chk("perr_pulse", bus.parity_err, 0);
    chk("perr_still_idle", bus.busy, 0);
    run_sched(KEY0, 1'b0, 0, cyc);
    chk("perr_ok_K1", got_q[0], K1);
`endif

    for (int t = 0; t < 12; t++) begin
      k = odd_par({$urandom, $urandom});
      run_sched(k, 1'($urandom_range(0, 1)), 4, cyc);
    end

    chk("done_count", n_done, n_sched);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/des_key_schedule.md
Name: des_key_schedule

Overview:
- Iterative DES subkey generator, directly upstream of the Feistel round function.
- Drives that function's 48-bit K input.
- Loads a 64-bit key, applies PC-1, then issues one PC-2 subkey per round (16 total) over a valid/ready handshake.
- Supports encrypt order (K1..K16) and decrypt order (K16..K1) by rotating C/D left or right, with no subkey storage.

Parameters:
- NUM_ROUNDS, 16, number of subkeys issued per key load; fixed by DES and not to be overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  load key_in/decrypt and begin a schedule; sampled only in IDLE.
- key_in  input  64  DES key; key_in[63] is DES bit 1; parity bits (DES bits 8,16,...,64) are ignored by PC-1.
- decrypt  input  1  0: issue K1..K16; 1: issue K16..K1. Sampled with start.
- subkey_out  output  48  current subkey; subkey_out[47] is DES bit 1. Reads 0 whenever subkey_valid=0.
- subkey_valid  output  1  subkey_out holds the subkey for round_idx.
- subkey_ready  input  1  consumer accepts the current subkey.
- round_idx  output  4  0..15 position in the issue sequence; reads 0 in IDLE.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse after the 16th subkey is accepted.
- parity_err  output  1  key rejected; tied 0 unless DES_KS_PARITY_CHECK_EN is defined.

Behaviour:
- Reset: state=IDLE; cd register=0; round_idx=0; subkey_valid, busy, done, parity_err all 0; subkey_out=0.
- States and transitions:
  - IDLE --start--> RUN.
  - RUN --(valid&ready at round_idx=15)--> DONE.
  - DONE --> IDLE unconditionally after 1 cycle; done=1 only in DONE.
- Start (cycle N in IDLE):
  - cd <= PC-1(key_in) (C=28 MSBs, D=28 LSBs).
  - Encrypt: C and D are first rotated left by SHIFT[1]=1.
  - Decrypt: no rotation.
  - round_idx <= 0.
- Cycle N+1: busy=1, subkey_valid=1, subkey_out = PC-2(cd), purely combinational from cd. Start-to-first-subkey latency is 1 cycle.
- Advance, on a cycle with subkey_valid & subkey_ready and round_idx<15:
  - round_idx++.
  - Encrypt: cd rotates left by SHIFT[round_idx+2].
  - Decrypt: cd rotates right by SHIFT[16-round_idx].
  - SHIFT[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - The rotation applies to C and D independently (28-bit wrap).
- Sustained throughput: ready held high gives one subkey per cycle, 16 consecutive cycles.
- Stall: ready low holds cd, round_idx and subkey_out stable; valid stays high and does not drop.
- Last round: handshake at round_idx=15 moves to DONE; valid drops the next cycle; cd is not rotated.
- start while busy or in DONE is ignored; key_in and decrypt changes after the start cycle have no effect.
- rst mid-schedule: returns to IDLE next edge with all outputs at reset values. A start asserted in the same cycle as rst is ignored.
- Encrypt end state: cumulative shift is 28, so cd returns to PC-1(key). The decrypt sequence therefore starts from an unrotated PC-1.

Optional Feature:
- Macro: DES_KS_PARITY_CHECK_EN.
- Defined:
  - On start in IDLE, check odd parity of each key_in byte.
  - If any byte has even parity: remain in IDLE, cd unchanged, parity_err=1 for exactly the next cycle, no subkey issued.
  - If all bytes pass: behaviour as normal.
- Undefined: no check; parity_err is constant 0.

Decomposition:
- Package des_ks_pkg holds:
  - PC1 table (56 entries).
  - PC2 table (48 entries).
  - SHIFT[1..16] constant.
  - State encoding: IDLE/RUN/DONE.
  - Width constants: KEY_W=64, CD_W=56, SUBKEY_W=48.
- One sub-module: des_pc2, the combinational 56->48 permutation.
- PC-1 and rotation stay in the top level.

Test Plan:
- Key 133457799BBCDFF1, decrypt=0, ready=1 -> valid one cycle after start; K1=1B02EFFC7072, K2=79AED9DBC9E5, K16=CB3D8B0E17F5; 16 consecutive valid cycles; done pulses once; then IDLE.
- Same key, decrypt=1 -> first subkey CB3D8B0E17F5 at round_idx=0; last subkey 1B02EFFC7072 at round_idx=15; the sequence is the exact reverse of the encrypt run.
- Random ready gaps (e.g. ready low 3 cycles at round_idx=5) -> subkey_out and round_idx stable while stalled; final sequence identical to the ready=1 run.
- start pulsed at round_idx=7 with a different key -> ignored; remaining subkeys still belong to 133457799BBCDFF1.
- rst asserted at round_idx=9 -> next cycle valid=0, busy=0, round_idx=0, subkey_out=0; a new start then gives K1=1B02EFFC7072.
- With DES_KS_PARITY_CHECK_EN defined, key 0000000000000000 -> parity_err=1 for one cycle, valid never rises. Key 133457799BBCDFF1 -> parity_err=0 and normal schedule.
